// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Optional lock-loss counter is enabled with RESET_SEQ_LOCK_LOSS_CNT_EN.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } rst_state_t;

   localparam int LOSS_CNT_W = 8;

   // One spare bit over the terminal value so a counter can never wrap before its compare.
   function automatic int cnt_width(input int limit);
      return $clog2(limit) + 1;
   endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Generic 2-FF synchroniser, asynchronously cleared to 0.
module reset_seq_sync #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // NOTE: non-blocking assignments so r_sync takes the pre-edge r_meta, giving two real flop stages.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/reset_seq.sv
// Staged reset generator: waits for a stable PLL lock, then releases reset domains in order.
// Build option RESET_SEQ_LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES         = 3,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP          = 16
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss
);

   localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
   localparam int GAP_W = cnt_width(STAGE_GAP);
   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

   rst_state_t            r_state,     w_state_nxt;
   logic [STB_W-1:0]      r_stb_cnt,   w_stb_cnt_nxt;
   logic [GAP_W-1:0]      r_gap_cnt,   w_gap_cnt_nxt;
   logic [IDX_W-1:0]      r_stage_idx, w_stage_idx_nxt;
   logic [NUM_STAGES-1:0] r_rst_stage, w_rst_stage_nxt;
   logic                  r_ready,     w_ready_nxt;

   logic w_lock_s;
   logic w_abort;

   reset_seq_sync #(.WIDTH(1)) u_lock_sync (
      .i_clk   (clk_sys),
      .i_rst   (rst),
      .i_async (pll_locked),
      .o_sync  (w_lock_s)
   );

   // Software requests are ignored while still waiting for lock.
   assign w_abort = (r_state != WAIT_LOCK) && (!w_lock_s || sw_rst_req);

   // NOTE: every next-state signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_stb_cnt_nxt   = r_stb_cnt;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_stage_idx_nxt = r_stage_idx;
      w_rst_stage_nxt = r_rst_stage;
      w_ready_nxt     = r_ready;

      if (w_abort) begin
         w_state_nxt     = WAIT_LOCK;
         w_stb_cnt_nxt   = '0;
         w_gap_cnt_nxt   = '0;
         w_stage_idx_nxt = '0;
         w_rst_stage_nxt = '1;
         w_ready_nxt     = 1'b0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_state_nxt   = STABLE;
                  w_stb_cnt_nxt = '0;
               end
            end
            STABLE: begin
               if (r_stb_cnt == STB_LAST) begin
                  w_rst_stage_nxt[0] = 1'b0;
                  w_stb_cnt_nxt      = '0;
                  w_gap_cnt_nxt      = '0;
                  if (NUM_STAGES == 1) begin
                     w_state_nxt = RUN;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_state_nxt     = RELEASE;
                     w_stage_idx_nxt = IDX_W'(1);
                  end
               end else begin
                  w_stb_cnt_nxt = r_stb_cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (r_gap_cnt == GAP_LAST) begin
                  w_gap_cnt_nxt = '0;
                  // Clearing every stage up to the index keeps release monotonic by construction.
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (IDX_W'(i) <= r_stage_idx) w_rst_stage_nxt[i] = 1'b0;
                  end
                  if (r_stage_idx == IDX_LAST) begin
                     w_state_nxt = RUN;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_stage_idx_nxt = r_stage_idx + 1'b1;
                  end
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + 1'b1;
               end
            end
            RUN: begin
               w_state_nxt = RUN;
            end
            default: begin
               w_state_nxt = WAIT_LOCK;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_state     <= WAIT_LOCK;
         r_stb_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_stage_idx <= '0;
         r_rst_stage <= '1;
         r_ready     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stb_cnt   <= w_stb_cnt_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_stage_idx <= w_stage_idx_nxt;
         r_rst_stage <= w_rst_stage_nxt;
         r_ready     <= w_ready_nxt;
      end
   end

   assign rst_stage = r_rst_stage;
   assign ready     = r_ready;

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
   logic                  w_lock_abort;
   logic [LOSS_CNT_W-1:0] r_lock_loss;

   // A lock drop coinciding with a software request is still one lock-loss event.
   assign w_lock_abort = (r_state != WAIT_LOCK) && !w_lock_s;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_lock_loss <= '0;
      end else if (w_lock_abort && (r_lock_loss != '1)) begin
         r_lock_loss <= r_lock_loss + 1'b1;
      end
   end

   assign lock_loss = r_lock_loss;
`else
   assign lock_loss = '0;
`endif

endmodule
